lab62_onchip_mem_arbiter: RTL

Two-master arbiter that shares the single-port 4×32 on-chip RAM between the Nios II data master (m0) and the sprite/tile fetch engine (m1). Sits between the two Avalon-MM masters and the RAM's `s1` port. Issues at most one RAM access per cycle, returns read data with fixed one-cycle latency, and tags each return to its owner.

---
 rtl/lab62_memarb_pkg.sv | 13 +
 rtl/lab62_memarb_pick.sv | 42 ++++
 rtl/lab62_onchip_mem_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/lab62_memarb_pkg.sv
// Shared types and sizing for the two-master on-chip RAM arbiter.
package lab62_memarb_pkg;

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_t;

    localparam int LAB62_RAM_ADDR_W = 2;
    localparam int LAB62_RAM_DATA_W = 32;
    localparam int LAB62_RD_LATENCY = 1;

endpackage

// File: rtl/lab62_memarb_pick.sv
// Combinational winner selection for the two RAM masters.
// LAB62_MEMARB_RR_EN selects round-robin; otherwise m0 has fixed priority.
module lab62_memarb_pick
    import lab62_memarb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_grant,
    output logic [1:0] gnt,
    output owner_t     winner
);

`ifdef LAB62_MEMARB_RR_EN
    always_comb begin
        winner = OWN_M0;
        if (req[0] && req[1]) begin
            // Whoever won last time yields under contention.
            winner = (last_grant == OWN_M0) ? OWN_M1 : OWN_M0;
        end else if (req[1]) begin
            winner = OWN_M1;
        end
        gnt = 2'b00;
        if (|req) begin
            gnt = (winner == OWN_M1) ? 2'b10 : 2'b01;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        winner = OWN_M0;
        if (!req[0] && req[1]) begin
            winner = OWN_M1;
        end
        gnt = 2'b00;
        if (|req) begin
            gnt = (winner == OWN_M1) ? 2'b10 : 2'b01;
        end
    end
`endif

endmodule

// File: rtl/lab62_onchip_mem_arbiter.sv
// Shares one single-port on-chip RAM between Nios II data master (m0) and the
// sprite/tile fetcher (m1). LAB62_MEMARB_RR_EN enables round-robin arbitration.
module lab62_onchip_mem_arbiter
    import lab62_memarb_pkg::*;
#(
    parameter int ADDR_W = LAB62_RAM_ADDR_W,
    parameter int DATA_W = LAB62_RAM_DATA_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W/8-1:0] ram_byteenable,
    output logic [DATA_W-1:0]   ram_writedata,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic                ram_clken,
    input  logic [DATA_W-1:0]   ram_readdata
);

    localparam int BE_W = DATA_W / 8;

    logic [1:0]        req;
    logic [1:0]        gnt;
    owner_t            winner;
    owner_t            last_grant;
    logic              any_gnt;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr, addr_q;
    logic [BE_W-1:0]   sel_be, be_q;
    logic [DATA_W-1:0] sel_wd, wd_q;
    logic              rd_pend;
    owner_t            rd_owner;

    // Requests are masked while in reset so nobody is granted before release.
    assign req = {m1_read | m1_write, m0_read | m0_write} & {2{reset_n}};

    lab62_memarb_pick u_pick (
        .req        (req),
        .last_grant (last_grant),
        .gnt        (gnt),
        .winner     (winner)
    );

    assign any_gnt = |gnt;

    always_comb begin
        sel_addr  = addr_q;
        sel_be    = be_q;
        sel_wd    = wd_q;
        sel_write = 1'b0;
        if (gnt[0]) begin
            sel_addr  = m0_address;
            sel_be    = m0_byteenable;
            sel_wd    = m0_writedata;
            sel_write = m0_write;
        end else if (gnt[1]) begin
            sel_addr  = m1_address;
            sel_be    = m1_byteenable;
            sel_wd    = m1_writedata;
            sel_write = m1_write;
        end
    end

    assign ram_address    = sel_addr;
    assign ram_byteenable = sel_be;
    assign ram_writedata  = sel_wd;
    assign ram_chipselect = any_gnt;
    assign ram_write      = any_gnt & sel_write;
    assign ram_clken      = 1'b1;

    assign m0_waitrequest = ~gnt[0];
    assign m1_waitrequest = ~gnt[1];

    // Holding registers keep the bus stable on idle cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q   <= '0;
            be_q     <= '0;
            wd_q     <= '0;
            rd_pend  <= 1'b0;
            rd_owner <= OWN_M0;
        end else begin
            if (any_gnt) begin
                addr_q <= sel_addr;
                be_q   <= sel_be;
                wd_q   <= sel_wd;
            end
            rd_pend <= any_gnt & ~sel_write;
            if (any_gnt && !sel_write) begin
                rd_owner <= winner;
            end
        end
    end

`ifdef LAB62_MEMARB_RR_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= OWN_M1;
        end else if (any_gnt) begin
            last_grant <= winner;
        end
    end
`else
    assign last_grant = OWN_M1;
`endif

    assign m0_readdatavalid = rd_pend & (rd_owner == OWN_M0);
    assign m1_readdatavalid = rd_pend & (rd_owner == OWN_M1);
    assign m0_readdata      = ram_readdata;
    assign m1_readdata      = ram_readdata;

endmodule
